// File: rtl/bm_frame_sequencer.sv
// Walks one frame of soft symbols through branch_metrics: forward pass, then backward pass.
// Each branch metric that comes back is tagged with its trellis index and direction.
module bm_frame_sequencer #(
    parameter int BITS            = 16,
    parameter int BITS_PER_SYMBOL = 2,
    parameter int MAX_FRAME       = 1024,
    parameter int ADDR_W          = $clog2(MAX_FRAME),
    parameter int BM_LATENCY      = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            start,
    input  logic [ADDR_W:0]                 frame_len,
    input  logic                            hold,
    output logic                            busy,
    output logic                            done,
    output logic                            mem_rd_en,
    output logic [ADDR_W-1:0]               mem_rd_addr,
    input  logic [BITS*BITS_PER_SYMBOL-1:0] mem_rd_data,
    output logic                            bm_in_valid,
    output logic [BITS*BITS_PER_SYMBOL-1:0] bm_symbol,
    input  logic                            bm_out_valid,
    output logic                            tag_valid,
    output logic [ADDR_W-1:0]               tag_index,
    output logic                            tag_dir,
    output logic                            err
);

    localparam int DEPTH = BM_LATENCY + 2;
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [ADDR_W:0] MAX_LEN = (ADDR_W + 1)'(MAX_FRAME);

    typedef enum logic [2:0] {IDLE, FWD, BWD, DRAIN, DONE} state_t;

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] ptr_reg, ptr_next;
    logic [ADDR_W:0]   len_reg, len_next;
    logic [ADDR_W:0]   len_clamped;
    logic              rd_en;
    logic              last_fwd;
    logic              drained;
    logic              bm_in_valid_reg;

    logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0]  fifo_cnt_reg;
    logic [CNT_W-1:0]  inflight_reg;
    logic              fifo_empty, fifo_full;
    logic              push, pop, inflight_dec;
    logic [ADDR_W:0]   fifo_mem [DEPTH];
    logic [ADDR_W:0]   head;
    logic              err_reg;

    assign len_clamped = (frame_len > MAX_LEN) ? MAX_LEN : frame_len;
    assign last_fwd    = ({1'b0, ptr_reg} == (len_reg - (ADDR_W + 1)'(1)));
    assign drained     = !bm_in_valid_reg && (inflight_reg == '0) && fifo_empty;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            ptr_reg   <= '0;
            len_reg   <= '0;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
            len_reg   <= len_next;
        end
    end

    // The pointer parks on the last index at each turn-around so the
    // backward pass starts on the same address the forward pass ended on.
    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        len_next   = len_reg;
        rd_en      = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    len_next   = len_clamped;
                    ptr_next   = '0;
                    state_next = (len_clamped == '0) ? DONE : FWD;
                end
            end
            FWD: begin
                if (!hold) begin
                    rd_en = 1'b1;
                    if (last_fwd) state_next = BWD;
                    else          ptr_next   = ptr_reg + ADDR_W'(1);
                end
            end
            BWD: begin
                if (!hold) begin
                    rd_en = 1'b1;
                    if (ptr_reg == '0) state_next = DRAIN;
                    else               ptr_next   = ptr_reg - ADDR_W'(1);
                end
            end
            DRAIN: begin
                if (drained) state_next = DONE;
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy        = (state_reg != IDLE);
    assign done        = (state_reg == DONE);
    assign mem_rd_en   = rd_en;
    assign mem_rd_addr = ptr_reg;
    assign bm_in_valid = bm_in_valid_reg;
    // Read data arrives the cycle after the strobe; qualify it with the strobe's delayed copy.
    assign bm_symbol   = bm_in_valid_reg ? mem_rd_data : '0;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign fifo_empty   = (fifo_cnt_reg == '0);
    assign fifo_full    = (fifo_cnt_reg == CNT_W'(DEPTH));
    assign tag_valid    = bm_out_valid && !fifo_empty;
    assign pop          = tag_valid;
    assign push         = rd_en && (!fifo_full || pop);
    assign inflight_dec = pop && (inflight_reg != '0);

    assign head      = fifo_mem[rd_ptr_reg];
    assign tag_index = head[ADDR_W:1];
    assign tag_dir   = head[0];
    assign err       = err_reg;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_slot
            logic [ADDR_W:0] slot_reg;
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    slot_reg <= '0;
                end else if (push && (wr_ptr_reg == PTR_W'(gi))) begin
                    slot_reg <= {ptr_reg, (state_reg == BWD)};
                end
            end
            assign fifo_mem[gi] = slot_reg;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_reg      <= '0;
            rd_ptr_reg      <= '0;
            fifo_cnt_reg    <= '0;
            inflight_reg    <= '0;
            bm_in_valid_reg <= 1'b0;
            err_reg         <= 1'b0;
        end else begin
            bm_in_valid_reg <= rd_en;
            if (push) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            if (pop)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            case ({push, pop})
                2'b10:   fifo_cnt_reg <= fifo_cnt_reg + CNT_W'(1);
                2'b01:   fifo_cnt_reg <= fifo_cnt_reg - CNT_W'(1);
                default: fifo_cnt_reg <= fifo_cnt_reg;
            endcase
            case ({bm_in_valid_reg, inflight_dec})
                2'b10:   inflight_reg <= inflight_reg + CNT_W'(1);
                2'b01:   inflight_reg <= inflight_reg - CNT_W'(1);
                default: inflight_reg <= inflight_reg;
            endcase
            // A metric with no matching tag means the pipeline lost sync; keep it flagged.
            if (bm_out_valid && fifo_empty) err_reg <= 1'b1;
        end
    end

endmodule
